// File: rtl/mem_ctrl.sv
// Byte-serial sequencer for the unified single-port RAM, arbitrating between
// instruction fetch and the load/store stage; assembles and extends load data.
module mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_signed_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  logic [2:0]          cnt_r;
  logic [2:0]          len_r;
  logic                own_mem_r;
  logic                signed_r;
  logic [ADDR_W-1:0]   base_r;
  logic [23:0]         wdata_hi_r;
  logic [23:0]         rbuf_r;

  logic                grant_mem_s;
  logic                grant_if_s;
  logic [ADDR_W-1:0]   grant_addr_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic [31:0]         raw_word_s;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic sgn);
    logic [31:0] res;
    case (n)
      3'd1:    res = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    res = {{16{sgn & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Byte 0 goes out at grant, so the latched copy only holds bytes 1..3.
  function automatic logic [7:0] store_byte(input logic [23:0] hi, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = hi[7:0];
      3'd1:    b = hi[15:8];
      3'd2:    b = hi[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Arbitration between simultaneous requests
  always_comb begin
    grant_mem_s = 1'b0;
    grant_if_s  = 1'b0;
    if (MEM_FIRST) begin
      grant_mem_s = mem_req_i;
      grant_if_s  = if_req_i & ~mem_req_i;
    end else begin
      grant_if_s  = if_req_i;
      grant_mem_s = mem_req_i & ~if_req_i;
    end
  end

  // Address of the next byte and the word assembled from the final read byte
  always_comb begin
    grant_addr_s = grant_mem_s ? mem_addr_i : if_addr_i;
    next_addr_s  = base_r + ADDR_W'(cnt_r) + ADDR_W'(3'd1);
    case (len_r)
      3'd1:    raw_word_s = {24'h000000, ram_din_i};
      3'd2:    raw_word_s = {16'h0000, ram_din_i, rbuf_r[7:0]};
      default: raw_word_s = {ram_din_i, rbuf_r};
    endcase
  end

  // Transfer sequencer with registered RAM-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      len_r       <= 3'd0;
      own_mem_r   <= 1'b0;
      signed_r    <= 1'b0;
      base_r      <= '0;
      wdata_hi_r  <= 24'h000000;
      rbuf_r      <= 24'h000000;
      ram_a_o     <= '0;
      ram_dout_o  <= 8'h00;
      ram_wr_o    <= 1'b0;
      if_data_o   <= 32'h00000000;
      if_done_o   <= 1'b0;
      mem_rdata_o <= 32'h00000000;
      mem_done_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ram_wr_o <= 1'b0;
          if (grant_mem_s || grant_if_s) begin
            own_mem_r  <= grant_mem_s;
            base_r     <= grant_addr_s;
            len_r      <= grant_mem_s ? len_bytes(mem_len_i) : 3'd4;
            signed_r   <= grant_mem_s & mem_signed_i;
            wdata_hi_r <= mem_wdata_i[31:8];
            cnt_r      <= 3'd0;
            ram_a_o    <= grant_addr_s;
            if (grant_mem_s && mem_we_i) begin
              ram_dout_o <= mem_wdata_i[7:0];
              ram_wr_o   <= 1'b1;
              state_r    <= WR;
            end else begin
              state_r    <= RD;
            end
          end
        end

        RD: begin
          ram_wr_o <= 1'b0;
          if (!own_mem_r && if_flush_i) begin
            state_r <= IDLE;
          end else begin
            // Read data trails its address by one cycle, so edge k holds byte k-1.
            case (cnt_r)
              3'd1:    rbuf_r[7:0]   <= ram_din_i;
              3'd2:    rbuf_r[15:8]  <= ram_din_i;
              3'd3:    rbuf_r[23:16] <= ram_din_i;
              default: rbuf_r        <= rbuf_r;
            endcase
            if (cnt_r < len_r - 3'd1) begin
              ram_a_o <= next_addr_s;
            end
            if (cnt_r == len_r) begin
              if (own_mem_r) begin
                mem_rdata_o <= extend(raw_word_s, len_r, signed_r);
                mem_done_o  <= 1'b1;
              end else begin
                if_data_o   <= raw_word_s;
                if_done_o   <= 1'b1;
              end
              state_r <= DONE;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end

        WR: begin
          if (cnt_r < len_r - 3'd1) begin
            ram_a_o    <= next_addr_s;
            ram_dout_o <= store_byte(wdata_hi_r, cnt_r);
            ram_wr_o   <= 1'b1;
            cnt_r      <= cnt_r + 3'd1;
          end else begin
            ram_wr_o   <= 1'b0;
            mem_done_o <= 1'b1;
            state_r    <= DONE;
          end
        end

        DONE: begin
          ram_wr_o   <= 1'b0;
          if_done_o  <= 1'b0;
          mem_done_o <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          ram_wr_o   <= 1'b0;
          if_done_o  <= 1'b0;
          mem_done_o <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
